// File: rtl/labk_stim_seq.sv
// Stimulus sequencer that sweeps the four (a,b) vectors into an and-not gate stage and counts mismatches on z.
// Optional simulation trace of each sampled vector is enabled by defining LABK_STIM_TRACE_EN.
module labk_stim_seq #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       z,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    logic [1:0] state_r;
    logic [1:0] state_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic [1:0] idx_s;
    logic [2:0] err_s;
    logic       busy_s;
    logic       mismatch_s;

    // Gate under test is expected to compute a & ~b on the currently driven vector.
    function automatic logic exp_and_not(input logic in_a, input logic in_b);
        return in_a & ~in_b;
    endfunction

    // Next-state, counter, vector index and error count selection.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = vec_idx;
        err_s      = err_count;
        mismatch_s = (z != exp_and_not(a, b));
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = DRIVE;
                    cnt_s   = SETTLE_LOAD;
                    idx_s   = 2'd0;
                    err_s   = 3'd0;
                end else begin
                    state_s = state_r;
                end
            end
            DRIVE: begin
                cnt_s = cnt_r - 8'd1;
                // A zero count cannot occur in normal flow; treat it as "settled" so the sweep never stalls.
                if (cnt_r <= 8'd1) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = DRIVE;
                end
            end
            SAMPLE: begin
                if (mismatch_s) begin
                    err_s = err_count + 3'd1;
                end else begin
                    err_s = err_count;
                end
                if (vec_idx != 2'd3) begin
                    idx_s   = vec_idx + 2'd1;
                    cnt_s   = SETTLE_LOAD;
                    state_s = DRIVE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 8'd0;
                idx_s   = 2'd0;
                err_s   = 3'd0;
            end
        endcase
        busy_s = (state_s == DRIVE) || (state_s == SAMPLE);
    end

    // State and registered outputs; done/pass reflect the DONE state one edge after it is entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 8'd0;
            vec_idx   <= 2'd0;
            err_count <= 3'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            vec_idx   <= idx_s;
            err_count <= err_s;
            a         <= busy_s & idx_s[1];
            b         <= busy_s & idx_s[0];
            busy      <= busy_s;
            done      <= (state_r == DONE);
            pass      <= (state_r == DONE) && (err_count == 3'd0);
        end
    end

`ifdef LABK_STIM_TRACE_EN
    // Trace of every sampled vector and the gate response.
    always_ff @(posedge clk) begin
        if (rst_n && (state_r == SAMPLE)) begin
            $display("a=%b b=%b z=%b", a, b, z);
        end else begin
        end
    end
`else
`endif

endmodule

// File: tb/tb_labk_stim_seq.sv
// Directed bench for labk_stim_seq: correct gate, stuck-at gates, slow settle, reset abort and held start.
module tb_labk_stim_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start2;
    logic [1:0] zmode;
    logic       z;
    logic       z2;
    logic       a, b, busy, done, pass;
    logic [1:0] vec_idx;
    logic [2:0] err_count;
    logic       a2, b2, busy2, done2, pass2;
    logic [1:0] vec_idx2;
    logic [2:0] err_count2;

    int checks;
    int failures;

    assign z  = (zmode == 2'd0) ? (a & ~b) : (zmode == 2'd1) ? 1'b0 : 1'b1;
    assign z2 = 1'b1;

    labk_stim_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .z(z),
        .a(a), .b(b), .vec_idx(vec_idx), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count)
    );

    labk_stim_seq #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start2), .z(z2),
        .a(a2), .b(b2), .vec_idx(vec_idx2), .busy(busy2),
        .done(done2), .pass(pass2), .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on the selected instance, then count edges until done rises.
    task automatic sweep(input int sel, input int exp_edges, input int exp_err,
                         input int exp_pass, input string tag);
        int  n;
        logic got;
        logic ab_bad;
        logic d;
        if (sel == 0) start = 1'b1;
        else          start2 = 1'b1;
        tick();
        start  = 1'b0;
        start2 = 1'b0;
        n = 0; got = 1'b0; ab_bad = 1'b0;
        while (!got && n < 60) begin
            tick();
            n++;
            if (sel == 0 && busy && ((a !== vec_idx[1]) || (b !== vec_idx[0]))) ab_bad = 1'b1;
            d = (sel == 0) ? done : done2;
            if (d === 1'b1) got = 1'b1;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_edges));
        if (sel == 0) begin
            check({tag, "_err"},     32'(err_count), 32'(exp_err));
            check({tag, "_pass"},    32'(pass),      32'(exp_pass));
            check({tag, "_vec_idx"}, 32'(vec_idx),   32'd3);
            check({tag, "_ab"},      32'({a, b}),    32'd0);
            check({tag, "_ab_track"}, 32'(ab_bad),   32'd0);
        end else begin
            check({tag, "_err"},     32'(err_count2), 32'(exp_err));
            check({tag, "_pass"},    32'(pass2),      32'(exp_pass));
        end
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst_n  = 1'b0;
        start  = 1'b1;
        start2 = 1'b1;
        zmode  = 2'd0;
        repeat (3) tick();
        check("reset_outputs", 32'({a, b, vec_idx, busy, done, pass, err_count}), 32'd0);
        check("reset_outputs3", 32'({a2, b2, vec_idx2, busy2, done2, pass2, err_count2}), 32'd0);
        rst_n  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        tick();
        check("idle_no_start", 32'(busy), 32'd0);

        // Correct gate, default settle.
        sweep(0, 9, 0, 1, "good");
        tick();
        check("done_held", 32'({done, pass}), 32'd3);

        // Stuck-at-0 and stuck-at-1 gate outputs.
        zmode = 2'd1;
        sweep(0, 9, 1, 0, "tie0");
        zmode = 2'd2;
        sweep(0, 9, 3, 0, "tie1");
        sweep(1, 17, 3, 0, "tie1_settle3");

        // Reset during vector 2, with start asserted in the reset cycle.
        zmode = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_vec_idx", 32'(vec_idx), 32'd2);
        check("mid_ab", 32'({a, b}), 32'd2);
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        check("abort_outputs", 32'({a, b, vec_idx, busy, done, pass, err_count}), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check("abort_idle", 32'(busy), 32'd0);
        sweep(0, 9, 0, 1, "after_abort");

        // Start held high: no restart mid-sweep, restart from DONE clears the count.
        zmode = 2'd1;
        start = 1'b1;
        tick();
        repeat (7) tick();
        check("held_busy", 32'({busy, vec_idx}), 32'd7);
        tick();
        check("held_done_state", 32'({busy, done, err_count}), 32'd1);
        tick();
        check("held_restart", 32'({done, pass, busy, vec_idx, err_count}), 32'b1010_0000);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 || n == 0) begin
            if (n >= 60) break;
            tick();
            n++;
        end
        check("rerun_latency", 32'(n), 32'd9);
        check("rerun_err", 32'(err_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
